// File: rtl/seg_disp_pkg.sv
// -----------------------------------------------------------------------------
// seg_disp_pkg
//   Shared types and helpers for the seven-segment display arbiter.
//   - state_e      : arbiter FSM states
//   - NUM_REQ      : number of content sources sharing the display
//   - REQ_*        : requester indices (bit positions in req / grant)
//   - winner_idx   : index of the highest-priority set request
//   - grant_idx    : index of the set bit in a one-hot grant
//   - above_mask   : request bits that outrank a given owner
//   - onehot       : index -> one-hot grant
// -----------------------------------------------------------------------------
package seg_disp_pkg;

    localparam int NUM_REQ    = 3;
    localparam int REQ_NORMAL = 0;
    localparam int REQ_MENU   = 1;
    localparam int REQ_ALERT  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Fixed priority: alert > menu > normal. Returns 0 when req is empty;
    // callers check |req before using the result.
    function automatic logic [1:0] winner_idx(input logic [NUM_REQ-1:0] req);
        if (req[REQ_ALERT])     return 2'(REQ_ALERT);
        else if (req[REQ_MENU]) return 2'(REQ_MENU);
        else                    return 2'(REQ_NORMAL);
    endfunction

    function automatic logic [1:0] grant_idx(input logic [NUM_REQ-1:0] g);
        if (g[REQ_ALERT])     return 2'(REQ_ALERT);
        else if (g[REQ_MENU]) return 2'(REQ_MENU);
        else                  return 2'(REQ_NORMAL);
    endfunction

    function automatic logic [NUM_REQ-1:0] above_mask(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b110;
            2'd1:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/seg_blink_gen.sv
// -----------------------------------------------------------------------------
// seg_blink_gen
//   Blink phase generator. A counter runs 0..BLINK_DIV-1 while `run` is high
//   and the phase toggles on each wrap. `clear` (grant change) or `run` low
//   forces counter and phase back to 0 so new content starts fully visible.
//
//   Ports:
//     clk   in   system clock
//     rst   in   synchronous active-high reset
//     clear in   restart the blink cycle on this edge
//     run   in   display owned on the coming cycle; low freezes at 0
//     phase out  phase value that takes effect on the coming edge; the parent
//                registers its digit mask from this so the mask and the phase
//                register change on the same edge
// -----------------------------------------------------------------------------
module seg_blink_gen
    import seg_disp_pkg::*;
#(
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic phase
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear || !run) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_d;

endmodule

// File: rtl/seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter
//   Shares one 8-digit scanned seven-segment display among three sources
//   (alert > menu > normal). Grants by fixed priority, holds a menu/alert
//   view for HOLD_CYCLES after its request drops, and drives the registered
//   nibble word and per-digit enable mask to the scan driver.
//
//   Build option: define SEG_ARB_BLINK_EN to include per-digit blinking.
//   Without it blink_mask is ignored and digit_en is FF while owned.
//
//   Ports:
//     clk          in   system clock
//     rst          in   synchronous active-high reset
//     req[2:0]     in   display requests (2 alert, 1 menu, 0 normal)
//     show_in[95:0] in  candidate words, requester i at [32i+31:32i]
//     blink_mask[23:0] in per-digit blink enables, requester i at [8i+7:8i]
//     grant[2:0]   out  one-hot owner, 000 when idle (registered)
//     show[31:0]   out  owner's word (registered)
//     digit_en[7:0] out visible-digit mask (registered)
//     switch_pulse out  one-cycle pulse on every grant change (registered)
// -----------------------------------------------------------------------------
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int BLINK_DIV   = 50_000_000,
    parameter int HOLD_CYCLES = 200_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*32-1:0]  show_in,
    input  logic [NUM_REQ*8-1:0]   blink_mask,
    output logic [NUM_REQ-1:0]     grant,
    output logic [31:0]            show,
    output logic [7:0]             digit_en,
    output logic                   switch_pulse
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [31:0]        show_q, show_d;
    logic [7:0]         digit_en_q, digit_en_d;
    logic               switch_pulse_q, switch_pulse_d;

    logic [1:0]         own_idx;    // current owner
    logic [1:0]         win_idx;    // highest pending request
    logic               higher;     // a request outranks the current owner
    logic               owned_d;    // display owned after this edge
    logic [1:0]         nxt_idx;    // owner after this edge
    logic               grant_chg;

    // ------------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------------
    always_comb begin
        own_idx = grant_idx(grant_q);
        win_idx = winner_idx(req);
        higher  = |(req & above_mask(own_idx));

        state_d = state_q;
        grant_d = grant_q;
        hold_d  = '0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = SERVE;
                    grant_d = onehot(win_idx);
                end else begin
                    grant_d = '0;
                end
            end

            SERVE: begin
                if (higher) begin
                    grant_d = onehot(win_idx);
                end else if (req[own_idx]) begin
                    state_d = SERVE;
                end else if (own_idx != 2'(REQ_NORMAL)) begin
                    state_d = HOLD;
                    hold_d  = HOLD_LOAD;
                end else if (|req) begin
                    // Normal owner dropped: hand straight to the next winner.
                    grant_d = onehot(win_idx);
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end

            HOLD: begin
                // Preemption and owner reassert are checked before expiry so
                // that a coincident expiry never causes a second grant change.
                if (higher) begin
                    state_d = SERVE;
                    grant_d = onehot(win_idx);
                end else if (req[own_idx]) begin
                    state_d = SERVE;
                end else if (hold_q == '0) begin
                    // Only lower-priority requests can be pending here.
                    if (|req) begin
                        state_d = SERVE;
                        grant_d = onehot(win_idx);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign owned_d   = (state_d != IDLE);
    assign nxt_idx   = grant_idx(grant_d);
    assign grant_chg = (grant_d != grant_q);

    // ------------------------------------------------------------------------
    // Output word and digit mask, computed for the owner after this edge so
    // they line up with grant.
    // ------------------------------------------------------------------------
`ifdef SEG_ARB_BLINK_EN
    logic blink_phase;

    seg_blink_gen #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk   (clk),
        .rst   (rst),
        .clear (grant_chg),
        .run   (owned_d),
        .phase (blink_phase)
    );

    always_comb begin
        digit_en_d = 8'h00;
        if (owned_d)
            digit_en_d = ~(blink_mask[{nxt_idx, 3'b000} +: 8] & {8{blink_phase}});
    end
`else
    // Blinking is compiled out; these sinks keep the unused inputs tidy.
    localparam int BLINK_DIV_unused = BLINK_DIV;
    logic blink_mask_unused;
    assign blink_mask_unused = ^blink_mask;

    always_comb begin
        digit_en_d = owned_d ? 8'hFF : 8'h00;
    end
`endif

    always_comb begin
        show_d         = owned_d ? show_in[{nxt_idx, 5'b00000} +: 32] : 32'h0;
        switch_pulse_d = grant_chg;
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            grant_q        <= '0;
            hold_q         <= '0;
            show_q         <= '0;
            digit_en_q     <= 8'h00;
            switch_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            hold_q         <= hold_d;
            show_q         <= show_d;
            digit_en_q     <= digit_en_d;
            switch_pulse_q <= switch_pulse_d;
        end
    end

    assign grant        = grant_q;
    assign show         = show_q;
    assign digit_en     = digit_en_q;
    assign switch_pulse = switch_pulse_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seg_display_arbiter
//   Directed bench for seg_display_arbiter with BLINK_DIV=4, HOLD_CYCLES=8.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at the
//   same point, so each check reflects the edge just taken.
// -----------------------------------------------------------------------------
module tb_seg_display_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [95:0] show_in;
    logic [23:0] blink_mask;
    logic [2:0]  grant;
    logic [31:0] show;
    logic [7:0]  digit_en;
    logic        switch_pulse;

    int n_tests;
    int n_fail;

    localparam logic [31:0] W0 = 32'h1234_5678;
    localparam logic [31:0] W1 = 32'hBBBB_0001;
    localparam logic [31:0] W2 = 32'hAAAA_0002;

    seg_display_arbiter #(
        .BLINK_DIV   (4),
        .HOLD_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .show_in      (show_in),
        .blink_mask   (blink_mask),
        .grant        (grant),
        .show         (show),
        .digit_en     (digit_en),
        .switch_pulse (switch_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Expected mask i cycles after a grant edge for a given blink mask.
    function automatic logic [7:0] exp_blink(input int i, input logic [7:0] m);
`ifdef SEG_ARB_BLINK_EN
        return ((i / 4) % 2 == 1) ? ~m : 8'hFF;
`else
        return (m == m) ? 8'hFF : 8'h00;
`endif
    endfunction

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        req        = 3'b111;
        show_in    = {W2, W1, W0};
        blink_mask = 24'h0;

        // Reset held with all requests pending.
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("rst_grant", grant, 3'b000);
            chk("rst_show", show, 32'h0);
            chk("rst_den", digit_en, 8'h00);
            chk("rst_pulse", switch_pulse, 1'b0);
        end
        rst = 1'b0;
        tick;
        chk("first_grant", grant, 3'b100);
        chk("first_show", show, W2);
        chk("first_pulse", switch_pulse, 1'b1);

        // Clean restart.
        rst = 1'b1; req = 3'b000;
        tick;
        chk("rst2_grant", grant, 3'b000);
        rst = 1'b0;
        tick;
        chk("idle_grant", grant, 3'b000);
        chk("idle_pulse", switch_pulse, 1'b0);

        // Priority and latency.
        req = 3'b001;
        tick;
        chk("n_grant", grant, 3'b001);
        chk("n_show", show, W0);
        chk("n_den", digit_en, 8'hFF);
        chk("n_pulse", switch_pulse, 1'b1);
        tick;
        chk("n_pulse_end", switch_pulse, 1'b0);
        req = 3'b011;
        tick;
        chk("m_grant", grant, 3'b010);
        chk("m_show", show, W1);
        chk("m_pulse", switch_pulse, 1'b1);
        tick;
        chk("m_pulse_end", switch_pulse, 1'b0);

        // Hold: drop menu with normal pending; show keeps tracking live.
        req = 3'b001;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) show_in[63:32] = 32'hCAFE_0003;
            tick;
            chk("hold_grant", grant, 3'b010);
            chk("hold_pulse", switch_pulse, 1'b0);
            if (i == 3) chk("hold_show_live", show, 32'hCAFE_0003);
        end
        show_in[63:32] = W1;
        tick;
        chk("hold_exp_grant", grant, 3'b001);
        chk("hold_exp_show", show, W0);
        chk("hold_exp_pulse", switch_pulse, 1'b1);

        // Reassert during hold at count 3: no expiry afterwards.
        req = 3'b011;
        tick;
        chk("ra_grant", grant, 3'b010);
        req = 3'b001;
        for (int i = 0; i < 5; i++) tick;   // drop edge plus four: count is 3
        chk("ra_hold_grant", grant, 3'b010);
        req = 3'b011;
        for (int i = 0; i < 12; i++) begin
            tick;
            chk("ra_stay_grant", grant, 3'b010);
            chk("ra_stay_pulse", switch_pulse, 1'b0);
        end

        // Alert preempts a hold.
        req = 3'b001;
        tick;
        tick;
        req = 3'b101;
        tick;
        chk("pre_grant", grant, 3'b100);
        chk("pre_show", show, W2);
        chk("pre_pulse", switch_pulse, 1'b1);

        // Alert drops with nothing pending: held 8 cycles, then idle.
        req = 3'b000;
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("ah_grant", grant, 3'b100);
        end
        tick;
        chk("ah_idle_grant", grant, 3'b000);
        chk("ah_idle_show", show, 32'h0);
        chk("ah_idle_den", digit_en, 8'h00);
        chk("ah_idle_pulse", switch_pulse, 1'b1);

        // One-cycle normal pulse: granted for exactly one cycle.
        req = 3'b001;
        tick;
        chk("np_grant", grant, 3'b001);
        req = 3'b000;
        tick;
        chk("np_drop_grant", grant, 3'b000);
        chk("np_drop_den", digit_en, 8'h00);
        chk("np_drop_pulse", switch_pulse, 1'b1);

        // Blink: menu mask 0F, then alert (mask 3C) preempts mid-blink.
        blink_mask = {8'h3C, 8'h0F, 8'h00};
        req = 3'b010;
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("blink_m", digit_en, exp_blink(i, 8'h0F));
        end
        req = 3'b110;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("blink_a", digit_en, exp_blink(i, 8'h3C));
            if (i == 0) chk("blink_a_grant", grant, 3'b100);
        end

        // Reset mid-operation.
        rst = 1'b1;
        tick;
        chk("midrst_grant", grant, 3'b000);
        chk("midrst_den", digit_en, 8'h00);
        rst = 1'b0; req = 3'b000;
        tick;
        chk("post_rst_grant", grant, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
